uart_mmio_ctrl: RTL
===================

# uart_mmio_ctrl

Register-mapped controller that sits between the JPU core's peripheral bus and the existing `uart_tx`/`uart_rx` pair. It owns the baud-divide configuration, buffers outgoing bytes in a TX FIFO and sequences them into `uart_tx` one at a time. It also captures `uart_rx` bytes into an RX FIFO with sticky overrun and framing-error flags, and raises a level interrupt for the core.

## Interface
- `DATA_WIDTH`, default `UART_DATA_WIDTH` (8): UART character width.
- `WORD_SIZE`, default 32: bus data width and `uart_divide` width.
- `FIFO_DEPTH`, default 8: entries per FIFO; power of two, 2..128.
- `DIVIDE_RESET`, default `UART_DIVIDE_OVERRIDE_SIM`: reset value of the DIVIDE register.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low; assert asynchronously, deassert synchronously upstream.
- `reg_sel`  in  2  register select: 0 DATA, 1 STATUS, 2 DIVIDE, 3 CTRL.
- `reg_wr`, `reg_rd`  in  1 each  single-cycle access strobes; mutually exclusive.
- `reg_wdata`  in  WORD_SIZE  write data.
- `reg_rdata`  out  WORD_SIZE  registered read data.
- `reg_ack`  out  1  pulses one cycle after every `reg_wr` or `reg_rd`.
- `uart_tx_data`  out  DATA_WIDTH, `uart_tx_valid`  out  1, `uart_tx_ready`  in  1: connect to `uart_tx`.
- `uart_rx_data`  in  DATA_WIDTH, `uart_rx_valid`  in  1, `uart_rx_err`  in  1: connect to `uart_rx`.
- `uart_divide`  out  WORD_SIZE  DIVIDE register; drives both UART blocks.
- `irq`  out  1  registered level interrupt.

## Operation
- Reset values: `reg_rdata`=0, `reg_ack`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `uart_divide`=DIVIDE_RESET, `irq`=0. Both FIFOs are empty, all sticky flags are 0, CTRL is 0, and the TX FSM is in IDLE.
- DATA write: pushes `reg_wdata[DATA_WIDTH-1:0]` into the TX FIFO. If the TX FIFO is full, the byte is dropped and sticky `tx_overflow` is set.
- DATA read: returns the RX FIFO head zero-extended and pops it. If the RX FIFO is empty, it returns 0, does not pop and sets no flag.
- STATUS read: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_busy (FSM not IDLE or TX FIFO non-empty), [5] rx_overrun, [6] rx_frame_err, [7] tx_overflow, [15:8] rx count, [23:16] tx count, other bits 0. STATUS writes are ignored.
- DIVIDE: read/write full word. A write takes effect on `uart_divide` the next cycle regardless of link activity; software changes it only when tx_busy=0.
- CTRL write:
  - [0] rx_irq_en and [1] txe_irq_en are stored.
  - [8]=1 clears all three sticky flags; [9]=1 flushes both FIFOs. Bits 8 and 9 are self-clearing and read back 0.
  - CTRL read returns [1:0].
- TX FSM:
  - IDLE -> SEND when the TX FIFO is non-empty and `uart_tx_ready`=1. On that edge the FSM loads `uart_tx_data` from the FIFO head and pops the FIFO.
  - SEND drives `uart_tx_valid`=1 for exactly one cycle, then goes to HOLD.
  - HOLD waits for `uart_tx_ready`=0, then goes to DRAIN. DRAIN waits for `uart_tx_ready`=1, then goes to IDLE.
  - `uart_tx_data` holds its value from SEND until the next load.
- RX capture, on `uart_rx_valid`:
  - `uart_rx_err`=1: set rx_frame_err, discard the byte.
  - Otherwise, if the RX FIFO is full and no pop occurs this cycle: set rx_overrun, discard the byte.
  - Otherwise: push the byte.
- Simultaneous events:
  - RX push and a DATA-read pop on a full FIFO both succeed; the count is unchanged.
  - A DATA-write push and an FSM pop on a full TX FIFO both succeed.
  - An error event and a CTRL[8] clear in the same cycle leave the flag set.
  - A flush in the same cycle as a push leaves the FIFO empty.
  - A flush does not abort an in-flight SEND/HOLD/DRAIN sequence.
- `irq` is registered from (rx_irq_en & !rx_empty) | (txe_irq_en & tx_empty & FSM==IDLE).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wrapping modulo 2·FIFO_DEPTH. Full means the pointers differ only in the MSB; count is wr−rd modulo that width.
- Reset asserted mid-operation forces every output to its reset value immediately, with no completion of a pending character.

## Timing
- Register access: strobe in cycle N; `reg_ack` and `reg_rdata` are valid in cycle N+1. `reg_rdata` holds until the next read.
- Register side effects (FIFO push/pop, flag clear, CTRL/DIVIDE update) occur at the end of cycle N.
- DATA write into an empty FIFO with FSM IDLE and `uart_tx_ready`=1: `uart_tx_valid` asserts in cycle N+2.
- Back-to-back characters are limited only by `uart_tx` ready timing. The minimum gap between `uart_tx_valid` pulses is 3 cycles.
- `uart_rx_valid` in cycle M makes the byte readable, with rx_empty=0, from cycle M+1. `irq` rises in cycle M+2.
- Sticky flags become visible in STATUS from the cycle after the event.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs. Required: all outputs at reset values, STATUS=0x00000006, `uart_divide`=DIVIDE_RESET.
- Loopback: set DIVIDE=`UART_DIVIDE_OVERRIDE_SIM`, write "abcdefg" to DATA, loop `uart_txd` to `uart_rxd`. Required: 7 `uart_tx_valid` pulses in order, RX count reaches 7, DATA reads return 0x61..0x67, then rx_empty=1.
- TX overflow: stall `uart_tx_ready`=0 and write 9 bytes at FIFO_DEPTH=8. Required: tx_full=1, tx_overflow=1, 9th byte never transmitted. CTRL write 0x100 clears the flag.
- RX overrun/frame error: inject 9 `uart_rx_valid` pulses with no reads, then 1 with `uart_rx_err`=1. Required: rx count=8, rx_overrun=1, rx_frame_err=1, first 8 bytes intact.
- Simultaneous full: RX FIFO full, DATA read coincident with `uart_rx_valid`. Required: rx count stays 8, no overrun, new byte last in order.
- IRQ and reset mid-send: with CTRL=0x3, the RX byte raises `irq` 2 cycles after `uart_rx_valid`. Assert `rst` during HOLD: `uart_tx_valid`=0 and the FSM is IDLE, with no further pulse after release while the FIFO is empty.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// Register-mapped front end for the uart_tx/uart_rx pair: baud divide register,
// TX/RX FIFOs, TX handshake sequencer, sticky error flags and a level interrupt.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif
`ifndef UART_DIVIDE_OVERRIDE_SIM
`define UART_DIVIDE_OVERRIDE_SIM 16
`endif

module uart_mmio_ctrl #(
    parameter int                   DATA_WIDTH   = `UART_DATA_WIDTH,
    parameter int                   WORD_SIZE    = 32,
    parameter int                   FIFO_DEPTH   = 8,
    parameter logic [WORD_SIZE-1:0] DIVIDE_RESET = WORD_SIZE'(`UART_DIVIDE_OVERRIDE_SIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            reg_sel,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [WORD_SIZE-1:0]  reg_wdata,
    output logic [WORD_SIZE-1:0]  reg_rdata,
    output logic                  reg_ack,
    output logic [DATA_WIDTH-1:0] uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_valid,
    input  logic                  uart_rx_err,
    output logic [WORD_SIZE-1:0]  uart_divide,
    output logic                  irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_DRAIN} tx_state_e;

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
    logic [WORD_SIZE-1:0]  divide_q, divide_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  ack_q, irq_q, irq_d;
    logic                  tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

    logic [PW-1:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0]         rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];

    logic                  data_wr, data_rd, divide_wr, ctrl_wr, flush, clear;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic [PW-1:0]         tx_count, rx_count;
    logic [DATA_WIDTH-1:0] tx_head, rx_head;
    logic [WORD_SIZE-1:0]  status_w;

    assign data_wr   = reg_wr && (reg_sel == 2'd0);
    assign data_rd   = reg_rd && (reg_sel == 2'd0);
    assign divide_wr = reg_wr && (reg_sel == 2'd2);
    assign ctrl_wr   = reg_wr && (reg_sel == 2'd3);
    assign flush     = ctrl_wr && reg_wdata[9];
    assign clear     = ctrl_wr && reg_wdata[8];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign tx_count = tx_wr_q - tx_rd_q;
    assign rx_count = rx_wr_q - rx_rd_q;
    assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign tx_pop  = (state_q == S_IDLE) && !tx_empty && uart_tx_ready;
    assign tx_push = data_wr && (!tx_full || tx_pop);
    assign rx_pop  = data_rd && !rx_empty;
    assign rx_push = uart_rx_valid && !uart_rx_err && (!rx_full || rx_pop);

    always_comb begin
        tx_wr_d = flush ? '0 : tx_wr_q + PW'(tx_push);
        tx_rd_d = flush ? '0 : tx_rd_q + PW'(tx_pop);
        rx_wr_d = flush ? '0 : rx_wr_q + PW'(rx_push);
        rx_rd_d = flush ? '0 : rx_rd_q + PW'(rx_pop);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= reg_wdata[DATA_WIDTH-1:0];
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= uart_rx_data;
    end

    // Set wins over clear so an event coincident with a clear is not lost.
    always_comb begin
        tx_ovf_d  = (tx_ovf_q  & ~clear) | (data_wr & tx_full & ~tx_pop);
        rx_ovr_d  = (rx_ovr_q  & ~clear) | (uart_rx_valid & ~uart_rx_err & rx_full & ~rx_pop);
        rx_ferr_d = (rx_ferr_q & ~clear) | (uart_rx_valid & uart_rx_err);
        divide_d  = divide_wr ? reg_wdata : divide_q;
        ctrl_d    = ctrl_wr ? reg_wdata[1:0] : ctrl_q;
        irq_d     = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & (state_q == S_IDLE));
    end

    always_comb begin
        status_w        = '0;
        status_w[0]     = tx_full;
        status_w[1]     = tx_empty;
        status_w[2]     = rx_empty;
        status_w[3]     = rx_full;
        status_w[4]     = (state_q != S_IDLE) || !tx_empty;
        status_w[5]     = rx_ovr_q;
        status_w[6]     = rx_ferr_q;
        status_w[7]     = tx_ovf_q;
        status_w[15:8]  = 8'(rx_count);
        status_w[23:16] = 8'(tx_count);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (reg_rd) begin
            rdata_d = '0;
            case (reg_sel)
                2'd0:    if (!rx_empty) rdata_d[DATA_WIDTH-1:0] = rx_head;
                2'd1:    rdata_d = status_w;
                2'd2:    rdata_d = divide_q;
                default: rdata_d[1:0] = ctrl_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (tx_pop) begin
                    state_d   = S_SEND;
                    tx_data_d = tx_head;
                end
            end
            S_SEND:  state_d = S_HOLD;
            S_HOLD:  if (!uart_tx_ready) state_d = S_DRAIN;
            default: if (uart_tx_ready) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tx_data_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            divide_q  <= DIVIDE_RESET;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rdata_q   <= rdata_d;
            ack_q     <= reg_wr | reg_rd;
            divide_q  <= divide_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            rx_ferr_q <= rx_ferr_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
        end
    end

    assign reg_rdata     = rdata_q;
    assign reg_ack       = ack_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_valid = (state_q == S_SEND);
    assign uart_divide   = divide_q;
    assign irq           = irq_q;

endmodule
